// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the memory access controller:
//   - state_t  : 2-bit FSM state encoding (IDLE, IF_ACC, LS_ACC, LS_ERR)
//   - GNT_IF / GNT_LS : encoding of the last-grant owner used by the arbiter
//   - CNT_W    : width of the access wait counter
//   - is_misaligned() : word-alignment test on the two low address bits
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_ACC = 2'd1,
        ST_LS_ACC = 2'd2,
        ST_LS_ERR = 2'd3
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LS = 1'b1;

    localparam int CNT_W = 4;

    // A load/store is word-aligned only when both low address bits are zero.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Loadable 4-bit down-counter that times a memory access.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset (count -> 0)
//   i_load     : load i_load_val (has priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one, saturating at zero
//   o_zero     : count is zero (last cycle of the access)
//   o_one      : count is one (next cycle will be the last one)
// -----------------------------------------------------------------------------
module wait_counter
    import mem_access_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_one
);

    logic [CNT_W-1:0] r_count;

    // Count register: load on grant, otherwise count down towards zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {CNT_W{1'b0}})) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {CNT_W{1'b0}});
    assign o_one  = (r_count == CNT_W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Arbitrates between an instruction-fetch port and a load/store port and runs
// a fixed-length (WAIT_CYCLES) access on a simple memory strobe interface.
// Misaligned load/stores are rejected with a one-cycle error completion.
//
// Parameters:
//   ADDR_W      : address width
//   DATA_W      : data width
//   WAIT_CYCLES : access length in cycles (1..15)
// Ports:
//   clk, rst                : clock / asynchronous active-low reset
//   if_req, if_addr         : fetch request (level) and address
//   if_done                 : fetch completion pulse
//   ls_req, ls_we, ls_addr,
//   ls_wdata                : load/store request (level), direction, address, data
//   ls_done, ls_err         : load/store completion pulse, misaligned-error pulse
//   mem_addr, mem_wdata     : memory address / write data (from grant latches)
//   mem_re, mem_we          : memory read / write strobes
//   ir_ld, mdr_ld           : instruction-register / memory-data-register load
//   busy                    : controller not in IDLE
//
// All control outputs are registered: they are computed from the next state
// and next counter value so that they line up with the state they describe.
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic              ir_ld,
    output logic              mdr_ld,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LP_LOAD_VAL   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic             LP_ONE_CYCLE  = (WAIT_CYCLES == 1) ? 1'b1 : 1'b0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;

    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_cnt_one;
    logic              w_we_nxt;
    logic              w_last_nxt;

    logic              w_busy_nxt;
    logic              w_mem_re_nxt;
    logic              w_mem_we_nxt;
    logic              w_if_done_nxt;
    logic              w_ir_ld_nxt;
    logic              w_ls_done_nxt;
    logic              w_ls_err_nxt;
    logic              w_mdr_ld_nxt;

    logic              r_busy;
    logic              r_mem_re;
    logic              r_mem_we;
    logic              r_if_done;
    logic              r_ir_ld;
    logic              r_ls_done;
    logic              r_ls_err;
    logic              r_mdr_ld;

    wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (LP_LOAD_VAL),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic with arbitration: ls wins unless it was granted last
    // time and a fetch is also waiting, which guarantees alternation.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_ls  = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ls_req && !((r_last_grant == GNT_LS) && if_req)) begin
                    w_grant_ls = 1'b1;
                    if (is_misaligned(ls_addr[1:0])) begin
                        w_state_nxt = ST_LS_ERR;
                    end else begin
                        w_state_nxt = ST_LS_ACC;
                        w_cnt_load  = 1'b1;
                    end
                end else if (if_req) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = ST_IF_ACC;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IF_ACC, ST_LS_ACC: begin
                // Request level is ignored here: an access always runs to completion.
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                    w_cnt_dec   = 1'b1;
                end
            end
            ST_LS_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant latches: address, direction, write data and last-grant owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_we         <= 1'b0;
            r_last_grant <= GNT_IF;
        end else if (w_grant_ls) begin
            r_addr       <= ls_addr;
            r_wdata      <= ls_wdata;
            r_we         <= ls_we;
            r_last_grant <= GNT_LS;
        end else if (w_grant_if) begin
            r_addr       <= if_addr;
            r_wdata      <= {DATA_W{1'b0}};
            r_we         <= 1'b0;
            r_last_grant <= GNT_IF;
        end else begin
            r_addr       <= r_addr;
            r_wdata      <= r_wdata;
            r_we         <= r_we;
            r_last_grant <= r_last_grant;
        end
    end

    // Output decode for the upcoming cycle. w_last_nxt says whether the counter
    // will read zero next cycle, i.e. whether that cycle is the last of the access.
    always_comb begin
        w_busy_nxt    = 1'b0;
        w_mem_re_nxt  = 1'b0;
        w_mem_we_nxt  = 1'b0;
        w_if_done_nxt = 1'b0;
        w_ir_ld_nxt   = 1'b0;
        w_ls_done_nxt = 1'b0;
        w_ls_err_nxt  = 1'b0;
        w_mdr_ld_nxt  = 1'b0;

        if (w_grant_ls) begin
            w_we_nxt = ls_we;
        end else if (w_grant_if) begin
            w_we_nxt = 1'b0;
        end else begin
            w_we_nxt = r_we;
        end

        if (w_cnt_load) begin
            w_last_nxt = LP_ONE_CYCLE;
        end else begin
            w_last_nxt = w_cnt_one;
        end

        case (w_state_nxt)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            ST_IF_ACC: begin
                w_busy_nxt    = 1'b1;
                w_mem_re_nxt  = 1'b1;
                w_if_done_nxt = w_last_nxt;
                w_ir_ld_nxt   = w_last_nxt;
            end
            ST_LS_ACC: begin
                w_busy_nxt    = 1'b1;
                w_mem_re_nxt  = ~w_we_nxt;
                w_mem_we_nxt  = w_we_nxt;
                w_ls_done_nxt = w_last_nxt;
                w_mdr_ld_nxt  = w_last_nxt & ~w_we_nxt;
            end
            ST_LS_ERR: begin
                w_busy_nxt    = 1'b1;
                w_ls_done_nxt = 1'b1;
                w_ls_err_nxt  = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears them at once, so an aborted access never pulses done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_if_done <= 1'b0;
            r_ir_ld   <= 1'b0;
            r_ls_done <= 1'b0;
            r_ls_err  <= 1'b0;
            r_mdr_ld  <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_mem_re  <= w_mem_re_nxt;
            r_mem_we  <= w_mem_we_nxt;
            r_if_done <= w_if_done_nxt;
            r_ir_ld   <= w_ir_ld_nxt;
            r_ls_done <= w_ls_done_nxt;
            r_ls_err  <= w_ls_err_nxt;
            r_mdr_ld  <= w_mdr_ld_nxt;
        end
    end

    assign busy      = r_busy;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign if_done   = r_if_done;
    assign ir_ld     = r_ir_ld;
    assign ls_done   = r_ls_done;
    assign ls_err    = r_ls_err;
    assign mdr_ld    = r_mdr_ld;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
